// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register built as a two-entry skid buffer with flush and stall counting.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] brachAdr,
    input  logic [DATA_W-1:0] ALUres,
    input  logic [DATA_W-1:0] RegValue,
    input  logic [REG_W-1:0]  writeReg,
    input  logic              zero,
    input  logic [4:0]        ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] brachAdrOut,
    output logic [DATA_W-1:0] ALUresOut,
    output logic [DATA_W-1:0] RegValueOut,
    output logic [REG_W-1:0]  writeRegOut,
    output logic              zeroOut,
    output logic [4:0]        ctrlOut,
    output logic              pcSrc,
    output logic              fwd_valid,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PW = 3*DATA_W + REG_W + 6;
    logic [PW-1:0]    in_pl, main_q, main_d, skid_q, skid_d;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept, drain;
    assign in_pl    = {brachAdr, ALUres, RegValue, writeReg, zero, ctrl};
    assign in_ready = !skid_v_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_v_q & out_ready;
    // ctrl occupies the low 5 payload bits; it is zeroed whenever an entry becomes a bubble
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        stall_d  = (main_v_q && !out_ready && !flush && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_d[4:0] = '0;
            skid_d[4:0] = '0;
        end else if (drain || !main_v_q) begin
            if (skid_v_q) begin
                main_d      = skid_q;
                main_v_d    = 1'b1;
                skid_v_d    = 1'b0;
                skid_d[4:0] = '0;
            end else if (accept) begin
                main_d   = in_pl;
                main_v_d = 1'b1;
            end else begin
                main_v_d    = 1'b0;
                main_d[4:0] = '0;
            end
        end else if (accept) begin
            skid_d   = in_pl;
            skid_v_d = 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            stall_q  <= stall_d;
        end
    end
    assign {brachAdrOut, ALUresOut, RegValueOut, writeRegOut, zeroOut, ctrlOut} = main_q;
    assign out_valid = main_v_q;
    assign pcSrc     = main_v_q & ctrlOut[4] & zeroOut;
    assign fwd_valid = main_v_q & ctrlOut[1] & (writeRegOut != '0);
    assign stall_cnt = stall_q;
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, the width of the ALU result, branch target and store data.
REQ-002 The module SHALL have parameter REG_W, default 5, the width of the destination register index.
REQ-003 The module SHALL have parameter CNT_W, default 16, the width of the stall counter.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the EX stage presents a valid instruction.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the stage can accept an instruction this cycle.
REQ-008 The module SHALL have ports brachAdr, ALUres and RegValue, each an input of DATA_W bits: branch target, ALU result and store data.
REQ-009 The module SHALL have port writeReg, input, REG_W bits: destination register index.
REQ-010 The module SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-011 The module SHALL have port ctrl, input, 5 bits: {Branch, MemRead, MemWrite, RegWrite, MemtoReg}.
REQ-012 The module SHALL have port flush, input, 1 bit: kill all held and incoming instructions.
REQ-013 The module SHALL have port out_valid, output, 1 bit: the MEM-side payload is valid.
REQ-014 The module SHALL have port out_ready, input, 1 bit: the MEM stage consumes the payload this cycle.
REQ-015 The module SHALL have ports brachAdrOut, ALUresOut, RegValueOut, writeRegOut, zeroOut and ctrlOut as outputs, each the same width as its input counterpart: the registered payload.
REQ-016 The module SHALL have port pcSrc, output, 1 bit: branch taken, equal to out_valid & ctrlOut[4] & zeroOut.
REQ-017 The module SHALL have port fwd_valid, output, 1 bit: forwarding qualifier, equal to out_valid & ctrlOut[1] & (writeRegOut != 0).
REQ-018 The module SHALL have port stall_cnt, output, CNT_W bits: saturating count of back-pressure cycles.

Function
REQ-019 The stage SHALL be a two-entry skid buffer holding a main entry (driving the outputs) and a skid entry, each with its own valid bit.
REQ-020 in_ready SHALL be !skid_valid, a direct function of registered state with no combinational path from out_ready.
REQ-021 An accept SHALL occur on cycles where in_valid & in_ready; a drain SHALL occur on cycles where out_valid & out_ready.
REQ-022 On an accept while the main entry is empty or draining, the incoming payload SHALL load into the main entry, giving a latency of exactly 1 cycle.
REQ-023 On an accept while the main entry is full and not draining, the incoming payload SHALL load into the skid entry, and in_ready SHALL be 0 on the next cycle.
REQ-024 On a drain while the skid entry is valid, the skid entry SHALL move to the main entry, and a simultaneous accept is impossible because in_ready is 0.
REQ-025 On a drain with no accept and an empty skid entry, out_valid SHALL go to 0 on the next cycle.
REQ-026 Payload SHALL leave in acceptance order, with none lost or duplicated.
REQ-027 While out_valid is 1 and out_ready is 0, the main-entry outputs SHALL hold stable.
REQ-028 When an entry is invalid, its ctrl field SHALL be 0, so that a bubble carries no memory or register-write side effects.
REQ-029 On flush, both valid bits and both ctrl fields SHALL clear on the next edge, and an accept in the same cycle SHALL be discarded.
REQ-030 Flush SHALL take priority over accept and drain.
REQ-031 Datapath fields MAY retain stale values after a flush.
REQ-032 On each cycle with out_valid & !out_ready & !flush, stall_cnt SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-033 Flush SHALL NOT clear stall_cnt.
REQ-034 Control, zero and writeReg SHALL pass through unmodified; no arithmetic is performed on the datapath.

Reset
REQ-035 Reset SHALL take effect on a rising edge of clock with reset = 1.
REQ-036 Reset SHALL clear both valid bits, all payload registers, ctrlOut and stall_cnt to 0.
REQ-037 After reset, out_valid, pcSrc and fwd_valid SHALL be 0 and in_ready SHALL be 1.
REQ-038 Reset SHALL override flush and any handshake in the same cycle.
REQ-039 Reset asserted mid-operation SHALL discard all held entries.

Verification
REQ-040 Flow-through: with out_ready=1, send ALUres=0x00000010, ctrl=5'b00010 and writeReg=3 -> one cycle later out_valid=1, ALUresOut=0x10 and fwd_valid=1.
REQ-041 Back-pressure: with out_ready=0, send A then B -> in_ready=0 after B and stall_cnt increments each cycle; then assert out_ready=1 -> A then B emerge on consecutive cycles, with in_ready=1 after A drains.
REQ-042 Flush: with both entries full and flush=1 while in_valid=1 with C -> next cycle out_valid=0, ctrlOut=0, in_ready=1, and C never appears.
REQ-043 Branch: accept zero=1 with ctrl=5'b10000 -> pcSrc=1 for exactly the cycles the entry is at the output; with zero=0 -> pcSrc=0.
REQ-044 Saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays there.
REQ-045 Reset mid-stall: both entries full, then assert reset for one cycle -> out_valid=0, stall_cnt=0, in_ready=1, and writeRegOut=0 with fwd_valid=0.
